// File: rtl/fetch_pkg.sv
// Shared constants for the fetch unit and its queue.
package fetch_pkg;
  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam int unsigned PC_INC           = 4;
endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of {pc, instr} entries with push/pop/flush and full/empty flags.
module fetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  input  logic            pop,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr,
  output logic            full,
  output logic            empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with redirect and a fetch queue.
// Optional saturating perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] iaddr,
  input  logic [XLEN-1:0] idata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_full_cycles
);
  logic [XLEN-1:0] pc;
  logic            q_full;
  logic            q_empty;
  logic            enq;
  logic            deq;
  logic [1:0]      unused_redirect_bits;

  assign unused_redirect_bits = redirect_pc[1:0];
  assign iaddr     = pc;
  assign out_valid = !q_empty;
  // Full blocks enqueue even when a dequeue frees a slot this cycle.
  assign enq = !q_full && !redirect_valid;
  assign deq = !q_empty && out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (enq)            pc <= pc + XLEN'(PC_INC);
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (enq),
    .push_pc    (pc),
    .push_instr (idata),
    .pop        (deq),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .full       (q_full),
    .empty      (q_empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] redirect_cnt;
  logic [31:0] full_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= '0;
      full_cnt     <= '0;
    end else begin
      if (redirect_valid && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 32'd1;
      if (q_full && full_cnt != '1)             full_cnt     <= full_cnt + 32'd1;
    end
  end

  assign perf_redirects   = redirect_cnt;
  assign perf_full_cycles = full_cnt;
`else
  assign perf_redirects   = '0;
  assign perf_full_cycles = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iaddr, idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic [31:0] perf_redirects, perf_full_cycles;

  logic [31:0] h_iaddr, h_idata, h_out_instr, h_out_pc, h_perf_r, h_perf_f;
  logic        h_out_valid;

  bit scramble = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_red, m_full;
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit scr);
    return scr ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F) : a;
  endfunction

  function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  assign idata   = mem_word(iaddr, scramble);
  assign h_idata = h_iaddr;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .perf_redirects(perf_redirects), .perf_full_cycles(perf_full_cycles)
  );

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .reset(reset), .iaddr(h_iaddr), .idata(h_idata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(h_out_valid), .out_ready(1'b1), .out_instr(h_out_instr), .out_pc(h_out_pc),
    .perf_redirects(h_perf_r), .perf_full_cycles(h_perf_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("iaddr", iaddr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_instr", out_instr, q_in[0]);
    end
    chk("perf_redirects", perf_redirects, exp_perf(m_red));
    chk("perf_full_cycles", perf_full_cycles, exp_perf(m_full));
  endtask

  task automatic model_step();
    bit enq, deq;
    if (reset) begin
      m_pc = 32'h0; m_red = 0; m_full = 0;
      q_pc.delete(); q_in.delete();
    end else begin
      if (q_pc.size() == DEPTH && m_full != 32'hFFFF_FFFF) m_full++;
      if (redirect_valid) begin
        if (m_red != 32'hFFFF_FFFF) m_red++;
        q_pc.delete(); q_in.delete();
        m_pc = redirect_pc & ~32'h3;
      end else begin
        enq = q_pc.size() < DEPTH;
        deq = (q_pc.size() != 0) && out_ready;
        if (deq) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
        if (enq) begin
          q_pc.push_back(m_pc);
          q_in.push_back(mem_word(m_pc, scramble));
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic finish_cycle();
    check_all();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hi_exp [4];
    hi_exp[0] = 32'h0; hi_exp[1] = 32'hFFFF_FFF8; hi_exp[2] = 32'hFFFF_FFFC; hi_exp[3] = 32'h0000_0000;

    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 32'h0; m_red = 0; m_full = 0;

    // Reset state
    @(negedge clk);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_perf_r", perf_redirects, 32'h0);
    chk("rst_perf_f", perf_full_cycles, 32'h0);
    chk("rst_hi_iaddr", h_iaddr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    reset = 1'b0;

    // Streaming fetch, memory word = address; high-reset instance wraps PC
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("hi_valid0", 32'(h_out_valid), 32'h0);
      else if (i < 4) chk("hi_out_pc", h_out_pc, hi_exp[i]);
      if (i >= 1) begin
        chk("seq_out_pc", out_pc, 32'((i - 1) * 4));
        chk("seq_out_instr", out_instr, 32'((i - 1) * 4));
      end
      finish_cycle();
    end

    // Stall: queue fills, PC holds
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("stall_iaddr", iaddr, 32'h10);
    chk("stall_full_cnt", perf_full_cycles, exp_perf(32'd6));
    finish_cycle();

    // Redirect with 3 entries queued
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("redir_valid", 32'(out_valid), 32'h0);
    chk("redir_iaddr", iaddr, 32'h100);
    finish_cycle();
    @(negedge clk);
    chk("redir_out_pc", out_pc, 32'h100);
    chk("redir_perf", perf_redirects, exp_perf(32'd1));
    finish_cycle();

    // Reset overrides same-cycle redirect
    out_ready = 1'b0;
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200; reset = 1'b1;
    tick();
    redirect_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rr_iaddr", iaddr, 32'h0);
    chk("rr_valid", 32'(out_valid), 32'h0);
    finish_cycle();

    // Randomized traffic
    scramble = 1'b1;
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 79) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      out_ready      = ($urandom_range(0, 99) < (((i / 100) % 2 == 1) ? 20 : 85));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address and instruction width.
REQ-002 Parameter DEPTH, default 4, fetch-queue entries; SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port iaddr, output, XLEN, instruction-memory address; equals current PC.
REQ-007 Port idata, input, XLEN, instruction word for iaddr, valid in the same cycle (combinational memory).
REQ-008 Port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 Port redirect_pc, input, XLEN, redirect target.
REQ-010 Port out_valid, output, 1, queue head holds a valid instruction.
REQ-011 Port out_ready, input, 1, decode stage accepts the head this cycle.
REQ-012 Port out_instr, output, XLEN, head instruction word.
REQ-013 Port out_pc, output, XLEN, PC of the head instruction.
REQ-014 Port perf_redirects, output, 32, count of redirect cycles.
REQ-015 Port perf_full_cycles, output, 32, count of cycles with the queue full.

Function
REQ-016 iaddr SHALL equal the PC register; there is no combinational path from any input to iaddr.
REQ-017 Enqueue fires when queue not full and redirect_valid=0: {PC, idata} written at tail, PC <= PC+4.
REQ-018 Dequeue fires when out_valid=1, out_ready=1 and redirect_valid=0: head entry is removed.
REQ-019 Queue full blocks enqueue even if dequeue fires the same cycle; PC and iaddr SHALL be held while full.
REQ-020 Simultaneous enqueue and dequeue on a non-full, non-empty queue SHALL leave the occupancy unchanged.
REQ-021 out_valid = (occupancy != 0); out_instr/out_pc are driven from the registered head entry only.
REQ-022 Latency: a word fetched in cycle N SHALL appear at the head no earlier than cycle N+1.
REQ-023 Redirect has priority over enqueue and dequeue: queue flushed (occupancy 0, pointers 0), PC <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-024 After a redirect in cycle N: out_valid=0 in cycle N+1, target instruction at the head in cycle N+2.
REQ-025 PC increments modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
REQ-026 Occupancy counter width is $clog2(DEPTH)+1; pointers wrap modulo DEPTH.

Reset
REQ-027 On reset: PC <= RESET_PC, occupancy and pointers 0, out_valid=0, perf counters 0.
REQ-028 Reset mid-operation discards all queued entries; reset overrides a same-cycle redirect.
REQ-029 Queue storage contents need not be reset; out_instr/out_pc are don't-care while out_valid=0.

Configuration
REQ-030 Macro FETCH_PERF_EN defined: perf_redirects increments each cycle redirect_valid=1, perf_full_cycles each cycle the queue is full; both saturate at 32'hFFFF_FFFF.
REQ-031 Macro FETCH_PERF_EN undefined: both perf outputs tied to 0 and no counter registers built.

Structure
REQ-032 Shared package fetch_pkg SHALL hold XLEN default, RESET_PC default, INSTR_NOP (32'h0000_0013) and the PC increment constant 4.
REQ-033 The circular buffer SHALL be a sub-module fetch_queue (DEPTH entries of {pc, instr}, push/pop/flush, full/empty); PC logic, redirect and perf counters stay in fetch_unit.

Verification
REQ-034 Reset released, out_ready=1, memory word = address -> out_pc 0,4,8,... one per cycle from cycle 2, out_instr = out_pc.
REQ-035 out_ready=0 for 10 cycles, DEPTH=4 -> after 4 fetches iaddr holds at 0x10, perf_full_cycles rises by 1 per full cycle (FETCH_PERF_EN).
REQ-036 Redirect to 0x103 while queue holds 3 entries -> next cycle out_valid=0, following cycle out_pc=0x100, perf_redirects=1.
REQ-037 Redirect and reset asserted in the same cycle -> PC=RESET_PC, out_valid=0 next cycle.
REQ-038 RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Build without FETCH_PERF_EN, repeat REQ-035 -> perf_redirects and perf_full_cycles remain 0.
